// File: rtl/sobel_scan_ctrl.sv
// Raster-scan controller for a 4-phase Sobel stage: drives pixel addresses, captures
// edge magnitudes and writes them (border-zeroed, optionally binarized) one column behind.
module sobel_scan_ctrl #(
    parameter int unsigned IMG_W   = 224,
    parameter int unsigned IMG_H   = 224,
    parameter int unsigned PIX_CYC = 4,
    parameter int unsigned THRESH  = 0
) (
    input  logic        fclk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] saddr,
    input  logic [7:0]  sdata,
    output logic [15:0] waddr,
    output logic [7:0]  wdata,
    output logic        we,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PhW = (PIX_CYC > 1) ? $clog2(PIX_CYC) : 1;
    localparam int unsigned XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [PhW-1:0] PhLast = PhW'(PIX_CYC - 1);
    localparam logic [XW-1:0]  XLast  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]  YLast  = YW'(IMG_H - 1);
    localparam logic [8:0]     Thr    = (THRESH > 255) ? 9'd256 : 9'(THRESH);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StFlush0,
        StFlush1,
        StFin
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    p_q, p_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           we_q, we_d;
    logic [15:0]    waddr_q, waddr_d;
    logic [7:0]     wdata_q, wdata_d;

    logic           prev_border;
    logic           last_pix;
    logic [7:0]     pix_val;

    always_ff @(posedge fclk) begin
        if (reset) begin
            state_q <= StIdle;
            p_q     <= '0;
            phase_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // The write target is pixel p-1: at x=0 it is the previous row's last column,
    // at x=1 it is column 0, otherwise it shares row y with p.
    always_comb begin
        prev_border = (x_q <= XW'(1)) || (y_q == '0) || (y_q == YLast);
        last_pix    = (x_q == XLast) && (y_q == YLast);
        if (prev_border) begin
            pix_val = 8'h00;
        end else if (THRESH == 0) begin
            pix_val = sdata;
        end else begin
            pix_val = ({1'b0, sdata} >= Thr) ? 8'hFF : 8'h00;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        phase_d = phase_q;
        x_d     = x_q;
        y_d     = y_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    p_d     = '0;
                    phase_d = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StScan: begin
                if (phase_q == PhLast) begin
                    phase_d = '0;
                    p_d     = p_q + 16'd1;
                    if (x_q == XLast) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    // Pixel 0's capture has no left neighbour to write back.
                    if (p_q != 16'd0) begin
                        we_d    = 1'b1;
                        waddr_d = p_q - 16'd1;
                        wdata_d = pix_val;
                    end
                    if (last_pix) begin
                        state_d = StFlush0;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StFlush0: begin
                // p_q now equals N, so this targets the final (border) pixel.
                state_d = StFlush1;
                we_d    = 1'b1;
                waddr_d = p_q - 16'd1;
                wdata_d = 8'h00;
            end
            StFlush1: begin
                state_d = StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        saddr = (state_q == StScan) ? p_q : 16'd0;
        busy  = (state_q == StScan) || (state_q == StFlush0) || (state_q == StFlush1);
        done  = (state_q == StFin);
        we    = we_q;
        waddr = waddr_q;
        wdata = wdata_q;
    end

endmodule
